// File: rtl/irq_requester.sv
// irq_requester
// Initiator side of a two-pulse user-interrupt handshake. Single-cycle events
// from N_SRC sources are latched into per-source pending bits. The pending
// sources are then sent one at a time over one IRQ_REQ/IRQ_ACK pair. Each
// request stays high until the first ACK. After that the block waits for a
// second ACK, which completes the handshake.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   src_pulse     one-cycle interrupt events, bit i = source i
//   IRQ_REQ       level request to the bridge
//   IRQ_VEC       index of the source being requested (valid while busy)
//   IRQ_ACK       acknowledge pulse from the bridge
//   pending       latched interrupts that have not been issued yet
//   busy          high in REQ or WAIT_CLR
//   irq_count     completed handshakes, wraps
//   err           sticky flags: bit0 ACK timeout, bit1 spurious ACK
//   err_clear     one-cycle clear of err (a same-cycle set wins)
module irq_requester #(
    parameter int N_SRC       = 4,
    parameter int VEC_W       = 4,
    parameter int ACK_TIMEOUT = 1000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_pulse,
    output logic             IRQ_REQ,
    output logic [VEC_W-1:0] IRQ_VEC,
    input  logic             IRQ_ACK,
    output logic [N_SRC-1:0] pending,
    output logic             busy,
    output logic [CNT_W-1:0] irq_count,
    output logic [1:0]       err,
    input  logic             err_clear
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_CLR} state_t;

    state_t           state, state_nx;
    logic [TMR_W-1:0] timer, timer_nx;
    logic             req_nx;
    logic [VEC_W-1:0] vec_nx, sel;
    logic [N_SRC-1:0] pend_nx, issue_mask;
    logic [CNT_W-1:0] cnt_nx;
    logic [1:0]       err_nx, err_set;

    // Pick the lowest set pending bit. The loop runs downward so that the
    // last match it sees, which is the lowest index, is the one kept.
    always_comb begin
        sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pending[i]) sel = VEC_W'(i);
        end
    end

    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        req_nx     = IRQ_REQ;
        vec_nx     = IRQ_VEC;
        cnt_nx     = irq_count;
        issue_mask = '0;
        err_set    = '0;
        case (state)
            IDLE: begin
                if (IRQ_ACK) err_set[1] = 1'b1;
                if (|pending) begin
                    issue_mask = N_SRC'(1) << sel;
                    vec_nx     = sel;
                    req_nx     = 1'b1;
                    timer_nx   = TMR_LOAD;
                    state_nx   = REQ;
                end
            end
            REQ: begin
                if (IRQ_ACK) begin
                    req_nx   = 1'b0;
                    timer_nx = TMR_LOAD;
                    state_nx = WAIT_CLR;
                end else if (timer == TMR_W'(1)) begin
                    // A timed-out source is dropped. It is not put back
                    // into pending.
                    req_nx     = 1'b0;
                    err_set[0] = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
            WAIT_CLR: begin
                if (IRQ_ACK) begin
                    cnt_nx   = irq_count + CNT_W'(1);
                    state_nx = IDLE;
                end else if (timer == TMR_W'(1)) begin
                    err_set[0] = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        // If a new pulse arrives on the same cycle its source is issued,
        // the pending bit stays set, so the new event is not lost.
        pend_nx = (pending & ~issue_mask) | src_pulse;
        err_nx  = (err_clear ? 2'b00 : err) | err_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            IRQ_REQ   <= 1'b0;
            IRQ_VEC   <= '0;
            pending   <= '0;
            busy      <= 1'b0;
            irq_count <= '0;
            err       <= '0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            IRQ_REQ   <= req_nx;
            IRQ_VEC   <= vec_nx;
            pending   <= pend_nx;
            busy      <= (state_nx != IDLE);
            irq_count <= cnt_nx;
            err       <= err_nx;
        end
    end

endmodule

// File: tb/tb_irq_requester.sv
module tb_irq_requester;

    localparam int N_SRC = 4;
    localparam int VEC_W = 4;
    localparam int ACK_TIMEOUT = 20;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_SRC-1:0] src_pulse;
    logic             IRQ_REQ;
    logic [VEC_W-1:0] IRQ_VEC;
    logic             IRQ_ACK;
    logic [N_SRC-1:0] pending;
    logic             busy;
    logic [CNT_W-1:0] irq_count;
    logic [1:0]       err;
    logic             err_clear;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    irq_requester #(
        .N_SRC(N_SRC), .VEC_W(VEC_W), .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .src_pulse(src_pulse),
        .IRQ_REQ(IRQ_REQ), .IRQ_VEC(IRQ_VEC), .IRQ_ACK(IRQ_ACK),
        .pending(pending), .busy(busy), .irq_count(irq_count),
        .err(err), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are driven, and outputs sampled, 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, then complete the handshake. Each ACK
    // is given 3 cycles after the previous phase begins.
    task automatic serve(input int exp_vec, input string tag);
        int n = 0;
        while (!IRQ_REQ && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(IRQ_REQ), 32'd1);
        chk({tag, "_vec"}, 32'(IRQ_VEC), 32'(exp_vec));
        repeat (2) tick();
        IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
        chk({tag, "_req_fall"}, 32'(IRQ_REQ), 32'd0);
        chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
        repeat (2) tick();
        IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
        exp_cnt++;
        chk({tag, "_done_idle"}, 32'(busy), 32'd0);
        chk({tag, "_count"}, 32'(irq_count), 32'(exp_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; src_pulse = '0; IRQ_ACK = 1'b0; err_clear = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_req", 32'(IRQ_REQ), 32'd0);
        chk("rst_vec", 32'(IRQ_VEC), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(irq_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Single event on source 2: latched at one edge, requested at the next.
        src_pulse = 4'b0100; tick(); src_pulse = '0;
        chk("single_pend", 32'(pending), 32'b0100);
        chk("single_noreq_yet", 32'(IRQ_REQ), 32'd0);
        tick();
        chk("single_req", 32'(IRQ_REQ), 32'd1);
        chk("single_pend_clr", 32'(pending), 32'd0);
        serve(2, "single");
        chk("single_vec_hold", 32'(IRQ_VEC), 32'd2);
        chk("single_err", 32'(err), 32'd0);

        // Priority: sources 3, 1 and 0 pulse together and are served lowest first.
        src_pulse = 4'b1011; tick(); src_pulse = '0;
        chk("prio_pend", 32'(pending), 32'b1011);
        serve(0, "prio0");
        chk("prio_gap0", 32'(IRQ_REQ), 32'd0);
        serve(1, "prio1");
        chk("prio_gap1", 32'(IRQ_REQ), 32'd0);
        serve(3, "prio3");
        chk("prio_pend_end", 32'(pending), 32'd0);

        // Re-pend: source 0 pulses again on the same edge it is issued.
        src_pulse = 4'b0001; tick();
        tick(); src_pulse = '0;
        chk("repend_req", 32'(IRQ_REQ), 32'd1);
        chk("repend_pend", 32'(pending), 32'b0001);
        serve(0, "repend_a");
        serve(0, "repend_b");
        chk("repend_pend_end", 32'(pending), 32'd0);

        // Timeout: no ACK comes, so the request drops 20 cycles after it rises.
        src_pulse = 4'b0001; tick(); src_pulse = '0;
        tick();
        chk("to_req_rise", 32'(IRQ_REQ), 32'd1);
        src_pulse = 4'b0010; tick(); src_pulse = '0;
        repeat (18) tick();
        chk("to_req_k19", 32'(IRQ_REQ), 32'd1);
        tick();
        chk("to_req_k20", 32'(IRQ_REQ), 32'd0);
        chk("to_err", 32'(err), 32'b01);
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_cnt", 32'(irq_count), 32'(exp_cnt));
        chk("to_queued", 32'(pending), 32'b0010);
        serve(1, "to_next");
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        chk("to_err_clr", 32'(err), 32'd0);

        // Spurious ACK while idle, then a clear, then a clear together with an ACK.
        IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
        chk("spur_err", 32'(err), 32'b10);
        chk("spur_idle", 32'(busy), 32'd0);
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        chk("spur_clr", 32'(err), 32'b00);
        IRQ_ACK = 1'b1; err_clear = 1'b1; tick(); IRQ_ACK = 1'b0; err_clear = 1'b0;
        chk("spur_set_wins", 32'(err), 32'b10);
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        chk("spur_clr2", 32'(err), 32'b00);

        // Reset asserted in WAIT_CLR while pending = 0110.
        src_pulse = 4'b0001; tick(); src_pulse = '0;
        tick();
        src_pulse = 4'b0110; tick(); src_pulse = '0;
        IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_pend", 32'(pending), 32'b0110);
        chk("mid_req_low", 32'(IRQ_REQ), 32'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mrst_req", 32'(IRQ_REQ), 32'd0);
        chk("mrst_pend", 32'(pending), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_cnt", 32'(irq_count), 32'd0);
        IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
        chk("late_ack_err", 32'(err), 32'b10);
        chk("late_ack_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_requester.md
Name: irq_requester

Overview:
- Initiator side of the two-pulse user-interrupt handshake. Collects single-cycle interrupt events from up to N_SRC sources and holds a pending bit per source.
- Serialises pending interrupts onto one IRQ_REQ/IRQ_ACK pair: request held until first ACK, dropped, then waits for the second ACK before the next request.
- Sits between user-logic event sources and the PCIe bridge (or its simulation model) that returns the two ACK pulses.

Parameters:
- N_SRC, 4, number of interrupt sources (1..16).
- VEC_W, 4, width of IRQ_VEC; must satisfy 2**VEC_W >= N_SRC.
- ACK_TIMEOUT, 1000, cycles allowed for each ACK phase before abort (>= 2).
- CNT_W, 16, width of the serviced-interrupt counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- src_pulse  in  N_SRC  one-cycle interrupt events, bit i = source i
- IRQ_REQ  out  1  interrupt request to bridge, level
- IRQ_VEC  out  VEC_W  index of source being requested; valid while busy
- IRQ_ACK  in  1  acknowledge pulse from bridge
- pending  out  N_SRC  latched, not-yet-issued interrupts
- busy  out  1  high in REQ or WAIT_CLR
- irq_count  out  CNT_W  count of fully completed handshakes, wraps
- err  out  2  sticky: bit0 timeout, bit1 spurious ACK
- err_clear  in  1  clears err (one cycle)

Behaviour:
- Reset: state IDLE; IRQ_REQ=0, IRQ_VEC=0, pending=0, busy=0, irq_count=0, err=0, timer=0.
- Reset wins over every other input, including mid-handshake. Pending events and the in-flight request are discarded.
- Pending update each cycle: pending <= (pending & ~issue_mask) | src_pulse.
  - If src_pulse[i] coincides with issue of source i, the bit stays set (set wins).
  - A repeat pulse on an already-pending source merges; it is not counted twice.
- States:
  - IDLE:
    - If pending != 0: pick the lowest set index k. Clear pending[k], IRQ_VEC<=k, IRQ_REQ<=1, timer<=ACK_TIMEOUT, go to REQ.
    - IRQ_REQ rises on the cycle after the selecting edge; events latched at edge t can be requested at t+1 at the earliest.
    - IRQ_ACK in IDLE sets err[1]; no state change.
  - REQ:
    - IRQ_ACK=1: IRQ_REQ<=0, timer<=ACK_TIMEOUT, go to WAIT_CLR.
    - Otherwise, if timer==1: IRQ_REQ<=0, set err[0], go to IDLE. No count; the source is dropped, not re-pended.
    - Otherwise timer decrements.
  - WAIT_CLR:
    - IRQ_ACK=1: irq_count<=irq_count+1 (mod 2**CNT_W), go to IDLE.
    - Otherwise, if timer==1: set err[0], go to IDLE.
    - Otherwise timer decrements.
- Minimum spacing: at least one IDLE cycle with IRQ_REQ=0 between consecutive requests; IRQ_REQ never stays high across two handshakes.
- IRQ_VEC holds its value from REQ entry until the next selection.
- busy = (state != IDLE), registered.
- err: the set condition beats err_clear in the same cycle; otherwise err_clear zeros both bits.
- Bits of src_pulse at index >= N_SRC do not exist. Ports sized exactly N_SRC.

Test Plan:
- Single event: pulse src 2 at cycle 10; responder ACKs 6 cycles after REQ rise, then 6 cycles after its fall. Required:
  - IRQ_REQ rises cycle 12 with IRQ_VEC=2.
  - IRQ_REQ falls the cycle after the first ACK.
  - irq_count=1 after the second ACK.
  - err=0.
- Priority/serialisation: pulse src 3,1,0 simultaneously. Required:
  - Requests issued in order VEC 0,1,3, each separated by >=1 idle cycle.
  - irq_count=3.
  - pending=0 at end.
- Re-pend collision: pulse src 0 on the exact cycle it is issued. Required: pending[0] stays 1 and a second request for VEC 0 follows; irq_count=2.
- Timeout: ACK_TIMEOUT=20, responder silent. Required:
  - IRQ_REQ drops 20 cycles after rising.
  - err=01, irq_count=0, state IDLE.
  - A queued src 1 is then requested normally.
- Spurious ACK / clear: ACK while IDLE gives err=10. Then assert err_clear with no new ACK, giving err=00. err_clear together with a spurious ACK leaves err=10.
- Reset mid-handshake: assert reset while in WAIT_CLR with pending=0110. Required:
  - Next cycle IRQ_REQ=0, pending=0, busy=0, irq_count=0.
  - A late ACK after reset sets err[1] only.
